// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline constants and hazard FSM state type
//
// Purpose : constants and types shared by the hazard control slice.
// Contents: REG_W   - register-index width (5)
//           XZR_IDX - zero-register index, never a hazard source
//           hz_state_e - hazard FSM states RUN / STALL / FLUSH

package hazard_ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned XZR_IDX = 31;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// rtl/hazard_ctrl_detect.sv - combinational load-use and flag hazard detection
//
// Purpose : compares the EX destination against the ID sources and flags
//           load-use and flag (set_flags -> B.cond) hazards.
// Ports   : memRead_EX, targetReg_EX    - EX load and its destination
//           Rn_ID, Rm_ID, useRn_ID, useRm_ID - ID sources and read enables
//           set_flags_EX, condBr_ID      - flag producer / consumer
//           load_use, flag_haz           - hazard flags (combinational)

module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned XZR_IDX = hazard_ctrl_pkg::XZR_IDX
) (
  input  logic             memRead_EX,
  input  logic [REG_W-1:0] targetReg_EX,
  input  logic [REG_W-1:0] Rn_ID,
  input  logic [REG_W-1:0] Rm_ID,
  input  logic             useRn_ID,
  input  logic             useRm_ID,
  input  logic             set_flags_EX,
  input  logic             condBr_ID,
  output logic             load_use,
  output logic             flag_haz
);

  logic rn_hit;
  logic rm_hit;

  assign rn_hit = useRn_ID && (Rn_ID == targetReg_EX);
  assign rm_hit = useRm_ID && (Rm_ID == targetReg_EX);

  // The zero register is never written, so a load to it cannot feed a consumer.
  assign load_use = memRead_EX && (targetReg_EX != REG_W'(XZR_IDX)) && (rn_hit || rm_hit);
  assign flag_haz = set_flags_EX && condBr_ID;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard FSM: load-use stall, flag stall, branch flush
//
// Purpose : drives PC / IF-ID / ID-EX controls from hazard and branch inputs.
// Params  : LOAD_LAT (1..3) bubble cycles per load-use hazard; XZR_IDX zero register.
// Ports   : clk, reset (async, active low)
//           memRead_EX, targetReg_EX, Rn_ID, Rm_ID, useRn_ID, useRm_ID,
//           set_flags_EX, condBr_ID, brTaken_EX  - hazard/branch inputs
//           pc_write, if_id_write, if_id_flush, id_ex_bubble, busy - controls
//           stall_cnt, flush_cnt - saturating event counters, only with
//           HAZARD_PERF_CNT_EN defined

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned XZR_IDX  = hazard_ctrl_pkg::XZR_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead_EX,
  input  logic [REG_W-1:0] targetReg_EX,
  input  logic [REG_W-1:0] Rn_ID,
  input  logic [REG_W-1:0] Rm_ID,
  input  logic             useRn_ID,
  input  logic             useRm_ID,
  input  logic             set_flags_EX,
  input  logic             condBr_ID,
  input  logic             brTaken_EX,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  // The first stall cycle is spent in RUN, so STALL covers the remaining LOAD_LAT-1.
  localparam logic [1:0] STALL_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  hz_state_e  state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       load_use, flag_haz;

  hazard_detect #(.XZR_IDX(XZR_IDX)) u_detect (
    .memRead_EX  (memRead_EX),
    .targetReg_EX(targetReg_EX),
    .Rn_ID       (Rn_ID),
    .Rm_ID       (Rm_ID),
    .useRn_ID    (useRn_ID),
    .useRm_ID    (useRm_ID),
    .set_flags_EX(set_flags_EX),
    .condBr_ID   (condBr_ID),
    .load_use    (load_use),
    .flag_haz    (flag_haz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    if (brTaken_EX) begin
      // A taken branch overrides any stall, including one already in progress.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = FLUSH;
      cnt_nxt      = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (load_use || flag_haz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
          if (load_use && (LOAD_LAT > 1)) begin
            state_nxt = STALL;
            cnt_nxt   = STALL_INIT;
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt == 2'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end
        FLUSH: begin
          // The wrong-path instruction fetched behind the branch is squashed here.
          if_id_flush = 1'b1;
          state_nxt   = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end

    // Hazard inputs may still be active while reset is held; keep outputs clean.
    if (!reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  assign busy = (state != RUN);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_ex_bubble && !if_id_flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush && (flush_cnt != '1))                  flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl at LOAD_LAT 1 and 3

module tb_hazard_ctrl;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy}
  localparam logic [4:0] N_RUN = 5'b11000;
  localparam logic [4:0] S_RUN = 5'b00010;
  localparam logic [4:0] S_BSY = 5'b00011;
  localparam logic [4:0] F_RUN = 5'b11110;
  localparam logic [4:0] F_BSY = 5'b11111;
  localparam logic [4:0] F_END = 5'b11101;

  logic       clk = 1'b0;
  logic       reset;
  logic       memRead_EX, useRn_ID, useRm_ID, set_flags_EX, condBr_ID, brTaken_EX;
  logic [4:0] targetReg_EX, Rn_ID, Rm_ID;
  logic       pw1, iw1, fl1, bb1, by1;
  logic       pw3, iw3, fl3, bb3, by3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [4:0] e1;
    logic [4:0] e3;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .memRead_EX(memRead_EX), .targetReg_EX(targetReg_EX),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
    .set_flags_EX(set_flags_EX), .condBr_ID(condBr_ID), .brTaken_EX(brTaken_EX),
    .pc_write(pw1), .if_id_write(iw1), .if_id_flush(fl1), .id_ex_bubble(bb1), .busy(by1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .memRead_EX(memRead_EX), .targetReg_EX(targetReg_EX),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
    .set_flags_EX(set_flags_EX), .condBr_ID(condBr_ID), .brTaken_EX(brTaken_EX),
    .pc_write(pw3), .if_id_write(iw3), .if_id_flush(fl3), .id_ex_bubble(bb3), .busy(by3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  wire [4:0] v1 = {pw1, iw1, fl1, bb1, by1};
  wire [4:0] v3 = {pw3, iw3, fl3, bb3, by3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] tr, input logic [4:0] rn,
                        input logic [4:0] rm, input logic urn, input logic urm,
                        input logic sf, input logic cb, input logic bt);
    memRead_EX = mr; targetReg_EX = tr; Rn_ID = rn; Rm_ID = rm;
    useRn_ID = urn; useRm_ID = urm; set_flags_EX = sf; condBr_ID = cb; brTaken_EX = bt;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic step(input string tag, input logic mr, input logic [4:0] tr,
                      input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                      input logic urm, input logic sf, input logic cb, input logic bt,
                      input logic [4:0] e1, input logic [4:0] e3);
    exp_t e;
    set_in(mr, tr, rn, rm, urn, urm, sf, cb, bt);
    exp_q.push_back('{tag, e1, e3});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.tag, "/L1"}, 32'(v1), 32'(e.e1));
    chk({e.tag, "/L3"}, 32'(v3), 32'(e.e3));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  task automatic ldu(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    step(tag, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  task automatic br(input string tag, input logic [4:0] e1, input logic [4:0] e3);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e1, e3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    // Reset held with a live load-use hazard on the inputs.
    reset = 1'b0;
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst/L1", 32'(v1), 32'(N_RUN));
    chk("rst/L3", 32'(v3), 32'(N_RUN));
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_sc", sc1, 32'd0);
    chk("rst_fc", fc1, 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    idle("idle0", N_RUN, N_RUN);

    // Rn load-use: one cycle at LOAD_LAT=1, three (busy on 2-3) at LOAD_LAT=3.
    ldu("lu_c1", S_RUN, S_RUN);
    idle("lu_c2", N_RUN, S_BSY);
    idle("lu_c3", N_RUN, S_BSY);
    idle("lu_end", N_RUN, N_RUN);

    // Zero register as destination never stalls.
    step("xzr", 1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, N_RUN, N_RUN);
    // Matching Rm that is not read.
    step("rm_off", 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N_RUN, N_RUN);
    // Matching Rm but not a load.
    step("no_ld", 1'b0, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, N_RUN, N_RUN);
    // Rm load-use.
    step("rm_lu", 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, S_RUN);
    idle("rm_c2", N_RUN, S_BSY);
    idle("rm_c3", N_RUN, S_BSY);
    idle("rm_end", N_RUN, N_RUN);

    // Flag hazard: single stall, no state change.
    step("flag", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_RUN, S_RUN);
    idle("flag_end", N_RUN, N_RUN);
    step("sf_only", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, N_RUN, N_RUN);

    // Taken branch beats a simultaneous load-use hazard.
    step("br_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F_RUN, F_RUN);
    idle("br_lu_f", F_END, F_END);
    idle("br_lu_end", N_RUN, N_RUN);

    // Back-to-back branches re-enter FLUSH.
    br("br_a", F_RUN, F_RUN);
    br("br_b", F_BSY, F_BSY);
    idle("br_b_f", F_END, F_END);
    idle("br_b_end", N_RUN, N_RUN);

    // Branch while LOAD_LAT=3 instance is mid-stall.
    ldu("st_lu", S_RUN, S_RUN);
    br("st_br", F_RUN, F_BSY);
    idle("st_f", F_END, F_END);
    idle("st_end", N_RUN, N_RUN);

    // Reset pulsed in cycle 2 of a LOAD_LAT=3 stall.
    ldu("rs_lu", S_RUN, S_RUN);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rs_pre/L3", 32'(v3), 32'(S_BSY));
    reset = 1'b0;
    #1;
    chk("rs_now/L1", 32'(v1), 32'(N_RUN));
    chk("rs_now/L3", 32'(v3), 32'(N_RUN));
    @(posedge clk); #1;
    reset = 1'b1;
    idle("rs_rel1", N_RUN, N_RUN);
    idle("rs_rel2", N_RUN, N_RUN);

    // Two load-use stalls and one taken branch from a fresh reset.
    ldu("pc_lu1", S_RUN, S_RUN);
    idle("pc_a1", N_RUN, S_BSY);
    idle("pc_a2", N_RUN, S_BSY);
    idle("pc_a3", N_RUN, N_RUN);
    ldu("pc_lu2", S_RUN, S_RUN);
    idle("pc_b1", N_RUN, S_BSY);
    idle("pc_b2", N_RUN, S_BSY);
    idle("pc_b3", N_RUN, N_RUN);
    br("pc_br", F_RUN, F_RUN);
    idle("pc_f", F_END, F_END);
    idle("pc_end", N_RUN, N_RUN);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt/L1", sc1, 32'd2);
    chk("flush_cnt/L1", fc1, 32'd2);
    chk("stall_cnt/L3", sc3, 32'd6);
    chk("flush_cnt/L3", fc3, 32'd2);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
